// File: rtl/cpu_pkg.sv
// Shared sequencer types and datapath widths for the 4-bit CPU.
package cpu_pkg;
   localparam int DATA_W = 4;
   localparam int ADDR_W = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      FETCH  = 3'd2,
      DECODE = 3'd3,
      EXEC   = 3'd4
   } seqStateT;
endpackage

// File: rtl/bp_compare.sv
// Breakpoint matcher; skipOnce masks the match so a launch from IDLE
// always executes the instruction sitting at the breakpoint address.
module bp_compare
   import cpu_pkg::*;
(
   input  logic              enable,
   input  logic              skipOnce,
   input  logic [ADDR_W-1:0] bpAddr,
   input  logic [ADDR_W-1:0] pc,
   output logic              hit
);
   assign hit = enable && !skipOnce && (pc == bpAddr);
endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: RAM preload, run/step/halt control and breakpoints,
// issuing the FETCH/DECODE/EXEC strobe pattern to the datapath.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int INSTR_CNT_W = 8
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   input  logic                   step,
   input  logic                   halt_req,
   input  logic                   bp_en,
   input  logic [ADDR_W-1:0]      bp_addr,
   input  logic [ADDR_W-1:0]      pc,
   input  logic                   load_valid,
   output logic                   load_ready,
   input  logic [ADDR_W-1:0]      load_addr,
   input  logic [DATA_W-1:0]      load_data,
   input  logic                   load_last,
   output logic                   ram_we,
   output logic [ADDR_W-1:0]      ram_addr,
   output logic [DATA_W-1:0]      ram_wdata,
   output logic                   fetch_en,
   output logic                   cp_en,
   output logic                   pc_en,
   output logic                   halted,
   output logic                   bp_hit,
   output logic [2:0]             state,
   output logic [INSTR_CNT_W-1:0] instr_cnt
);
   seqStateT stateQ, stateD;
   logic     stepQ, stepD;
   logic     fetchTry, fromIdle, bpMatch, bpTrip;

   bp_compare uBp (
      .enable   (bp_en),
      .skipOnce (fromIdle),
      .bpAddr   (bp_addr),
      .pc       (pc),
      .hit      (bpMatch)
   );

   // Every would-be entry into FETCH goes through the breakpoint gate.
   assign bpTrip = fetchTry && bpMatch;

   always_comb begin
      stateD   = stateQ;
      stepD    = stepQ;
      fetchTry = 1'b0;
      fromIdle = 1'b0;
      case (stateQ)
         IDLE: begin
            if (load_valid) begin
               stateD = LOAD;
            end else if (step) begin
               fetchTry = 1'b1;
               fromIdle = 1'b1;
               stepD    = 1'b1;
            end else if (run && !halt_req) begin
               fetchTry = 1'b1;
               fromIdle = 1'b1;
            end
         end
         LOAD:   if (load_valid && load_last) stateD = IDLE;
         FETCH:  stateD = DECODE;
         DECODE: stateD = EXEC;
         EXEC: begin
            if (stepQ) begin
               stateD = IDLE;
               stepD  = 1'b0;
            end else if (halt_req || !run) begin
               stateD = IDLE;
            end else begin
               fetchTry = 1'b1;
            end
         end
         default: stateD = IDLE;
      endcase
      if (fetchTry) stateD = bpTrip ? IDLE : FETCH;
   end

   // Strobes and status are registered from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         stepQ     <= 1'b0;
         fetch_en  <= 1'b0;
         cp_en     <= 1'b0;
         pc_en     <= 1'b0;
         halted    <= 1'b1;
         bp_hit    <= 1'b0;
         instr_cnt <= '0;
      end else begin
         stateQ   <= stateD;
         stepQ    <= stepD;
         fetch_en <= (stateD == FETCH);
         cp_en    <= (stateD == EXEC);
         pc_en    <= (stateD == EXEC);
         halted   <= (stateD == IDLE) || (stateD == LOAD);
         if (bpTrip)
            bp_hit <= 1'b1;
         else if (fetchTry && fromIdle)
            bp_hit <= 1'b0;
         if (stateD == EXEC) instr_cnt <= instr_cnt + 1'b1;
      end
   end

   assign state      = stateQ;
   assign load_ready = (stateQ == LOAD);
   assign ram_we     = load_ready && load_valid;
   assign ram_addr   = load_addr;
   assign ram_wdata  = load_data;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Random + directed bench for cpu_sequencer against an instruction-level
// reference model, with a small PC block model driving the pc input.
module tb_cpu_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0, step = 1'b0, halt_req = 1'b0;
   logic       bp_en = 1'b0;
   logic [3:0] bp_addr = 4'd0;
   logic [3:0] pc;
   logic       load_valid = 1'b0, load_last = 1'b0;
   logic [3:0] load_addr = 4'd0, load_data = 4'd0;
   logic       load_ready, ram_we, fetch_en, cp_en, pc_en, halted, bp_hit;
   logic [3:0] ram_addr, ram_wdata;
   logic [2:0] state;
   logic [7:0] instr_cnt;

   logic [3:0] pcQ = 4'd0;
   logic       pcClr = 1'b1;

   int nChk = 0, nFail = 0;
   int weCnt = 0, fetchCnt = 0;

   // Reference model: instruction in flight + its cycle index (0..2).
   bit mLoad = 0, mBusy = 0, mSingle = 0, mHit = 0;
   int mPhase = 0, mCnt = 0, mPc = 0;

   cpu_sequencer #(.INSTR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
      .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
      .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
      .load_data(load_data), .load_last(load_last),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .fetch_en(fetch_en), .cp_en(cp_en), .pc_en(pc_en),
      .halted(halted), .bp_hit(bp_hit), .state(state), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   // PC block: advances on the edge ending EXEC and presents the advanced
   // value while pc_en is high.
   always @(posedge clk) begin
      if (pcClr) pcQ <= 4'd0;
      else if (pc_en) pcQ <= pcQ + 4'd1;
   end
   assign pc = pcQ + {3'b000, pc_en};

   task automatic chk(input string tag, input int obs, input int exp);
      nChk++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void modelStep();
      bit execDone;
      execDone = mBusy && (mPhase == 2);
      if (pcClr) mPc = 0;
      else if (execDone) mPc = (mPc + 1) % 16;
      if (!rst_n) begin
         mLoad = 0; mBusy = 0; mSingle = 0; mHit = 0; mCnt = 0; mPhase = 0;
      end else if (mLoad) begin
         if (load_valid && load_last) mLoad = 0;
      end else if (!mBusy) begin
         if (load_valid) mLoad = 1;
         else if (step || (run && !halt_req)) begin
            mBusy = 1; mPhase = 0; mSingle = step; mHit = 0;
         end
      end else if (mPhase < 2) begin
         mPhase++;
         if (mPhase == 2) mCnt = (mCnt + 1) % 256;
      end else begin
         if (mSingle || halt_req || !run) begin
            mBusy = 0; mSingle = 0;
         end else if (bp_en && (mPc == int'(bp_addr))) begin
            mBusy = 0; mHit = 1;
         end else begin
            mPhase = 0;
         end
      end
   endfunction

   task automatic cyc(input bit r, input bit ru, input bit st, input bit h,
                      input bit lv, input bit ll, input logic [3:0] la,
                      input logic [3:0] ld);
      @(negedge clk);
      rst_n = r; run = ru; step = st; halt_req = h;
      load_valid = lv; load_last = ll; load_addr = la; load_data = ld;
      #1;
      chk("load_ready", load_ready, mLoad);
      chk("ram_we", ram_we, mLoad && lv);
      if (ram_we) begin
         weCnt++;
         chk("ram_addr", ram_addr, la);
         chk("ram_wdata", ram_wdata, ld);
      end
      @(posedge clk);
      modelStep();
      #1;
      pcClr = 1'b0;
      if (fetch_en) fetchCnt++;
      chk("fetch_en", fetch_en, mBusy && mPhase == 0);
      chk("cp_en", cp_en, mBusy && mPhase == 2);
      chk("pc_en", pc_en, mBusy && mPhase == 2);
      chk("halted", halted, !mBusy);
      chk("bp_hit", bp_hit, mHit);
      chk("state", state, mLoad ? 1 : (mBusy ? 2 + mPhase : 0));
      chk("instr_cnt", instr_cnt, mCnt);
   endtask

   task automatic doReset();
      pcClr = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
   endtask

   initial begin
      // Reset, then free-run for 12 cycles.
      doReset();
      chk("rst_halted", halted, 1);
      chk("rst_cnt", instr_cnt, 0);
      fetchCnt = 0;
      for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("run12_cnt", instr_cnt, 4);
      chk("run12_fetches", fetchCnt, 4);
      chk("run12_exec", cp_en, 1);
      cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);

      // Load burst with run held high throughout.
      weCnt = 0;
      cyc(1, 1, 0, 0, 1, 0, 4'd0, 4'd5);
      for (int i = 0; i < 4; i++)
         cyc(1, 1, 0, 0, 1, i == 3, 4'(i), 4'(5 + i));
      chk("load_we_pulses", weCnt, 4);
      chk("load_done_state", state, 0);
      cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);

      // Single step, with a second step pulse landing in DECODE.
      doReset();
      cyc(1, 0, 1, 0, 0, 0, 4'd0, 4'd0);
      cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);
      cyc(1, 0, 1, 0, 0, 0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("step_cnt", instr_cnt, 1);
      chk("step_idle", halted, 1);

      // Breakpoint at pc=3, then resume with run still high.
      doReset();
      bp_en = 1'b1; bp_addr = 4'd3;
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("bp_stop_hit", bp_hit, 1);
      chk("bp_stop_pc", pc, 3);
      chk("bp_stop_cnt", instr_cnt, 3);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("bp_resume_hit", bp_hit, 0);
      chk("bp_resume_pc", pc, 4);
      chk("bp_resume_cnt", instr_cnt, 4);
      bp_en = 1'b0;

      // halt_req raised in DECODE, then reset during FETCH.
      doReset();
      cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      cyc(1, 1, 0, 1, 0, 0, 4'd0, 4'd0);
      chk("halt_exec", cp_en, 1);
      cyc(1, 1, 0, 1, 0, 0, 4'd0, 4'd0);
      chk("halt_idle", halted, 1);
      cyc(1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("pre_rst_fetch", fetch_en, 1);
      cyc(0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
      cyc(1, 0, 0, 0, 0, 0, 4'd0, 4'd0);
      chk("rst_mid_cp", cp_en, 0);
      chk("rst_mid_cnt", instr_cnt, 0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit lv;
         if (i % 200 == 0) begin
            bp_en   = ($urandom_range(0, 1) == 1);
            bp_addr = 4'($urandom_range(0, 15));
         end
         lv = mLoad ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 14) == 0);
         cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
             $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
             lv, $urandom_range(0, 2) == 0,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      $display("%0d/%0d checks passed", nChk - nFail, nChk);
      $finish;
   end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter INSTR_CNT_W, default 8, width of retired-instruction counter.
REQ-002 SHALL have ports: clk input 1 system clock; rst_n input 1 synchronous active-low reset.
REQ-003 SHALL have ports: run input 1 level, free-run request; step input 1 single-cycle pulse, execute one instruction; halt_req input 1 level, stop at next instruction boundary.
REQ-004 SHALL have ports: bp_en input 1 breakpoint enable; bp_addr input 4 breakpoint program address; pc input 4 current program count from PC block.
REQ-005 SHALL have ports: load_valid input 1; load_ready output 1; load_addr input 4; load_data input 4; load_last input 1 final word of a RAM load burst.
REQ-006 SHALL have ports: ram_we output 1; ram_addr output 4; ram_wdata output 4 (RAM preload path, muxed externally).
REQ-007 SHALL have ports: fetch_en output 1 program-ROM fetch strobe; cp_en output 1 Addr/Acc register latch enable; pc_en output 1 PC advance enable.
REQ-008 SHALL have ports: halted output 1; bp_hit output 1 sticky; state output 3 encoded state; instr_cnt output INSTR_CNT_W retired count.

Function
REQ-009 SHALL implement states IDLE, LOAD, FETCH, DECODE, EXEC; all outputs registered except load_ready and ram_* (decoded from state and inputs).
REQ-010 Each instruction SHALL take exactly 3 cycles: FETCH (fetch_en=1), DECODE (all strobes 0), EXEC (cp_en=1, pc_en=1, single cycle each).
REQ-011 In IDLE, priority SHALL be load_valid > step > run; load_valid -> LOAD; step -> FETCH with single-step flag set; run && !halt_req -> FETCH.
REQ-012 In LOAD, load_ready SHALL be 1; each cycle with load_valid=1 SHALL assert ram_we=1 with ram_addr=load_addr, ram_wdata=load_data combinationally; load_valid && load_last -> IDLE next cycle.
REQ-013 Outside LOAD, ram_we SHALL be 0 and load_ready SHALL be 0; run/step/halt_req SHALL be ignored during LOAD.
REQ-014 After EXEC: single-step flag set -> IDLE and clear flag; else halt_req=1 or run=0 -> IDLE; else -> FETCH.
REQ-015 Breakpoint SHALL be checked on entry to FETCH from EXEC: bp_en && pc==bp_addr -> IDLE instead, bp_hit=1; no strobe issued.
REQ-016 Transition IDLE->FETCH (run or step) SHALL skip the breakpoint check for that first instruction, so resume from a breakpoint address progresses.
REQ-017 bp_hit SHALL stay 1 until the next IDLE->FETCH transition, which clears it.
REQ-018 halt_req asserted mid-instruction SHALL NOT abort it; EXEC completes, then IDLE.
REQ-019 step asserted while not in IDLE SHALL be ignored (not queued).
REQ-020 instr_cnt SHALL increment by 1 in each EXEC cycle, wrapping from 2^INSTR_CNT_W-1 to 0.
REQ-021 halted SHALL be 1 exactly when state is IDLE or LOAD.
REQ-022 pc input SHALL be pc value after EXEC's pc_en has taken effect (PC updates at same edge leaving EXEC).

Reset
REQ-023 rst_n=0 at a clk edge SHALL force IDLE, clear single-step flag, bp_hit=0, instr_cnt=0, fetch_en=cp_en=pc_en=0, halted=1.
REQ-024 Reset during LOAD or mid-instruction SHALL abandon it with no further strobes; partial load words already written remain in RAM.
REQ-025 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-026 State enum (3-bit, IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4) SHALL live in shared package cpu_pkg, also exporting DATA_W=4, ADDR_W=4.
REQ-027 Block SHALL be one module plus one sub-module bp_compare (enable, 4-bit equality, skip-once flag).

Verification
REQ-028 Reset, run=1 for 12 cycles -> fetch_en at cycles 1,4,7,10; cp_en/pc_en at 3,6,9,12; instr_cnt=4.
REQ-029 Load burst addr 0..3 data 5,6,7,8, load_last on 4th -> four ram_we pulses with matching addr/data; IDLE after; run ignored during burst.
REQ-030 IDLE, step pulse with run=0 -> exactly one fetch_en/cp_en/pc_en triplet, back to IDLE, instr_cnt=1; step during DECODE ignored.
REQ-031 bp_en=1, bp_addr=3, run=1 from pc=0 -> three instructions, IDLE with bp_hit=1 at pc=3; run kept 1 -> resumes, executes pc=3 instruction, bp_hit=0.
REQ-032 halt_req raised in DECODE -> EXEC completes, then IDLE; rst_n=0 during FETCH -> IDLE next edge, no cp_en, instr_cnt=0.
